// File: rtl/sap_u_pkg.sv
// sap_u_pkg: shared bus constants, the bus_out_port state encoding and one double-dabble step.
package sap_u_pkg;

    localparam int BUS_W = 8;
    localparam int BCD_W = 12;

    typedef enum logic [2:0] {IDLE, CONVERT, SHIFT_LO, SHIFT_HI, LATCH} bus_out_state_t;

    // Add 3 to every digit of 5 or more, then shift the next binary bit in.
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] v, input logic b);
        logic [BCD_W-1:0] a;
        a = v;
        for (int i = 0; i < BCD_W / 4; i++)
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        return {a[BCD_W-2:0], b};
    endfunction

endpackage

// File: rtl/bcd_convert.sv
// bcd_convert: sequential double-dabble, one binary bit per cycle; the start edge consumes the first bit.
// done rises after BUS_W steps and holds, together with bcd, until the next start.
module bcd_convert
    import sap_u_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BUS_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);
    localparam int CW = $clog2(BUS_W + 1);
    localparam logic [CW-1:0] LAST = CW'(BUS_W);

    logic [BUS_W-1:0] sh;
    logic [CW-1:0]    cnt;

    assign done = cnt == LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd <= '0;
            sh  <= '0;
            cnt <= '0;
        end else if (start) begin
            bcd <= dd_step('0, bin[BUS_W-1]);
            sh  <= {bin[BUS_W-2:0], 1'b0};
            cnt <= CW'(1);
        end else if (cnt != '0 && !done) begin
            bcd <= dd_step(bcd, sh[BUS_W-1]);
            sh  <= {sh[BUS_W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_out_port.sv
// bus_out_port: captures the system bus on load and serialises it to a 74HC595-style shift/latch chain.
// Define BUS_OUT_PORT_BCD_EN to shift out three BCD digits of the captured byte instead of the raw bits.
module bus_out_port
    import sap_u_pkg::*;
#(
    parameter int DATA_W    = BUS_W,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] bus,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] q,
    output logic              sr_data,
    output logic              sr_clk,
    output logic              sr_latch
);
`ifdef BUS_OUT_PORT_BCD_EN
    localparam int NBITS = BCD_W;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    bus_out_state_t   state;
    logic [NBITS-1:0] sh, sh_adv;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bits;
    logic             div_end;

    function automatic logic first_bit(input logic [NBITS-1:0] v);
        return MSB_FIRST ? v[NBITS-1] : v[0];
    endfunction

    assign busy    = ~ready;
    assign div_end = cnt == DIV_LAST;
    assign sh_adv  = MSB_FIRST ? sh << 1 : sh >> 1;

`ifdef BUS_OUT_PORT_BCD_EN
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    bcd_convert u_bcd (
        .clk  (clk),
        .reset(reset),
        .start(state == IDLE && load),
        .bin  (BUS_W'(bus)),
        .done (conv_done),
        .bcd  (conv_bcd)
    );
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ready    <= 1'b1;
            q        <= '0;
            sh       <= '0;
            cnt      <= '0;
            bits     <= '0;
            sr_data  <= 1'b0;
            sr_clk   <= 1'b0;
            sr_latch <= 1'b0;
        end else begin
            // Every timed phase starts its divider at zero.
            cnt <= (state == IDLE || state == CONVERT || div_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (load) begin
                    q     <= bus;
                    ready <= 1'b0;
                    bits  <= '0;
`ifdef BUS_OUT_PORT_BCD_EN
                    state <= CONVERT;
`else
                    state   <= SHIFT_LO;
                    sh      <= bus;
                    sr_data <= first_bit(bus);
`endif
                end
`ifdef BUS_OUT_PORT_BCD_EN
                CONVERT: if (conv_done) begin
                    state   <= SHIFT_LO;
                    sh      <= conv_bcd;
                    sr_data <= first_bit(conv_bcd);
                end
`endif
                SHIFT_LO: if (div_end) begin
                    state  <= SHIFT_HI;
                    sr_clk <= 1'b1;
                end
                SHIFT_HI: if (div_end) begin
                    sr_clk <= 1'b0;
                    bits   <= bits + 1'b1;
                    sh     <= sh_adv;
                    if (bits == BIT_LAST) begin
                        state    <= LATCH;
                        sr_latch <= 1'b1;
                    end else begin
                        state   <= SHIFT_LO;
                        sr_data <= first_bit(sh_adv);
                    end
                end
                LATCH: if (div_end) begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    sr_latch <= 1'b0;
                    sr_data  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_out_port.md
Name: bus_out_port

Overview:
- Output port that reads the 8-bit system bus. It is the consumer of the value the ALU and registers drive onto the bus.
- On a load strobe it captures the bus value into a held output register.
- It then serialises that value to an external 74HC595-style shift-register and latch chain that drives the display.
- It gives the control logic a ready/busy handshake so that loads are never lost silently.

Parameters:
- DATA_W, 8: bus and output register width.
- CLK_DIV, 4: system clocks per half-period of sr_clk; also the sr_latch pulse width. Legal values are 1 or greater.
- MSB_FIRST, 1: when 1, bits shift out MSB first; when 0, LSB first.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- load, input, 1: capture request. Sampled only while ready=1.
- bus, input, DATA_W: system bus value.
- ready, output, 1: high when idle and able to accept a load.
- busy, output, 1: always the inverse of ready.
- q, output, DATA_W: last captured bus value, held until the next accepted load.
- sr_data, output, 1: serial data to the external shift register.
- sr_clk, output, 1: shift clock to the external shift register.
- sr_latch, output, 1: storage/latch clock to the external shift register.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE.
  - q=0, sr_data=0, sr_clk=0, sr_latch=0.
  - ready=1, busy=0.
  - Counters are cleared.
  - Reset asserted mid-transfer aborts the transfer immediately. No latch pulse is issued.
- States: IDLE, [CONVERT], SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - ready=1.
  - load=1 at an edge means q<=bus and the shift register is loaded from bus. The next state is SHIFT_LO, or CONVERT if BCD is enabled.
  - ready drops in the cycle after the accepting edge.
- SHIFT_LO:
  - sr_clk=0.
  - sr_data presents the current bit (MSB or LSB per MSB_FIRST) for CLK_DIV cycles, then go to SHIFT_HI.
- SHIFT_HI:
  - sr_clk=1 for CLK_DIV cycles; sr_data holds stable.
  - Then advance the bit counter.
  - If NBITS bits are done, go to LATCH; otherwise go to SHIFT_LO.
- LATCH:
  - sr_clk=0, sr_latch=1 for CLK_DIV cycles, then return to IDLE.
  - sr_data returns to 0 in IDLE.
- NBITS = DATA_W, or 12 when BCD is enabled.
- Busy duration: busy is high for exactly 2*CLK_DIV*NBITS + CLK_DIV cycles after the accepting edge, plus the CONVERT cycles when BCD is enabled.
- Loads while busy are ignored. q and the transfer in progress are unaffected.
- A load held continuously is accepted again in the first IDLE cycle. Back-to-back transfers therefore have exactly one idle cycle between them.
- The bus value matters only at the accepting edge.
- sr_clk and sr_latch are registered outputs and are glitch-free.
- sr_data changes only while sr_clk=0.

Optional Feature:
- Macro: BUS_OUT_PORT_BCD_EN.
- Defined:
  - After capture, a CONVERT state runs an iterative double-dabble: one bus bit per cycle, DATA_W cycles in total, DATA_W=8 only.
  - It yields 3 BCD digits (12 bits: hundreds, tens, ones), which are shifted out as NBITS=12.
  - q still holds the raw binary value.
- Undefined:
  - No CONVERT state; the raw DATA_W bits are shifted.

Decomposition:
- Shared package sap_u_pkg holds:
  - the bus width constant BUS_W=8;
  - the state enum bus_out_state_t (IDLE, CONVERT, SHIFT_LO, SHIFT_HI, LATCH);
  - the BCD width constant BCD_W=12.
- One sub-module, bcd_convert, is natural. It is a sequential double-dabble with start/done, instantiated only under BUS_OUT_PORT_BCD_EN.

Test Plan:
- Reset check: assert reset low mid-SHIFT_HI, then release.
  - Required: all outputs are 0 and ready=1 immediately.
  - Required: no sr_latch pulse follows.
  - Required: the next load of 0x3C transfers normally.
- Basic transfer: CLK_DIV=2, MSB_FIRST=1, bus=0xA5, one-cycle load.
  - Required: q=0xA5.
  - Required: sampled at sr_clk rising edges, sr_data reads 1,0,1,0,0,1,0,1.
  - Required: busy lasts 34 cycles, with one sr_latch pulse 2 cycles wide at the end.
- Load while busy: load 0x0F, then assert load with bus=0xF0 on cycle 5.
  - Required: the second load is ignored; q stays 0x0F and the shifted bits are 00001111.
- Continuous load: hold load=1 with bus=0x81.
  - Required: successive transfers separated by exactly one ready=1 cycle; each shifts 0x81.
- Bit order: MSB_FIRST=0, bus=0x01.
  - Required: the first bit shifted is 1 and the remaining seven are 0.
- BCD enabled: BUS_OUT_PORT_BCD_EN, CLK_DIV=2, bus=0xFF.
  - Required: shifted bits are 0010_0101_0101 (0x255).
  - Required: busy lasts 8+48+2=58 cycles, and q=0xFF.
